// File: rtl/rr_grant_ctrl_if.sv
// Bus between the requesters and the round-robin grant controller.
// master: requester side (drives req/done); slave: the controller.
interface rr_grant_ctrl_if #(
    parameter int NREQ = 6,
    parameter int IDW  = 3
);
    logic [0:NREQ-1] req;
    logic            done;
    logic [0:NREQ-1] grant;
    logic [IDW-1:0]  grant_id;
    logic            grant_valid;
    logic            timeout;

    modport master (
        output req,
        output done,
        input  grant,
        input  grant_id,
        input  grant_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output grant_id,
        output grant_valid,
        output timeout
    );
endinterface

// File: rtl/rr_grant_ctrl.sv
// Round-robin arbiter/sequencer: grants one requester at a time, holds the
// grant until done (or until the requester withdraws), then inserts a single
// idle gap cycle before re-arbitrating from the requester after the last
// winner. All outputs are registered.
//
// Optional build macro RR_GRANT_TIMEOUT_EN: adds a hold counter that forces a
// release after TIMEOUT granted cycles and pulses 'timeout' for one cycle.
// Without it, 'timeout' is tied to 0 and a grant is held indefinitely.
module rr_grant_ctrl #(
    parameter int NREQ    = 6,
    parameter int IDW     = 3,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_grant_ctrl_if.slave   bus
);

    // Elaboration-time sanity check of the parameter set.
    if (((1 << IDW) < NREQ) || (TIMEOUT < 2) || (TIMEOUT > 65536)) begin : g_param_check
        $error("rr_grant_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        GAP     = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [IDW-1:0]  ptr_reg, ptr_next;
    logic [0:NREQ-1] grant_reg, grant_next;
    logic [IDW-1:0]  id_reg, id_next;
    logic            valid_reg, valid_next;
    logic            timeout_reg, timeout_next;

    // Arbitration result for the current request vector.
    logic            pick_found;
    logic [IDW-1:0]  pick_id;
    logic [0:NREQ-1] pick_onehot;

    // Release bookkeeping for the active grant.
    logic            rel_cond;
    logic [IDW-1:0]  ptr_after;

`ifdef RR_GRANT_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          cnt_limit;
    assign cnt_limit = (cnt_reg == CW'(TIMEOUT - 1));
`endif

    // Search requesters starting at ptr, wrapping, first set bit wins.
    always_comb begin
        logic [IDW:0] sum;
        pick_found = 1'b0;
        pick_id    = '0;
        sum        = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_reg} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            if (!pick_found && bus.req[sum[IDW-1:0]]) begin
                pick_found = 1'b1;
                pick_id    = sum[IDW-1:0];
            end
        end
    end

    // One-hot decode of the winning index.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_dec
        assign pick_onehot[gi] = (pick_id == IDW'(gi));
    end

    // Pointer value after releasing the current owner (wraps NREQ-1 -> 0).
    assign ptr_after = (id_reg == IDW'(NREQ - 1)) ? '0 : id_reg + 1'b1;

    // A grant ends on done or when its requester drops its request.
    assign rel_cond = bus.done || !bus.req[id_reg];

    // Next-state and next-output logic.
    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        grant_next   = grant_reg;
        id_next      = id_reg;
        valid_next   = valid_reg;
        timeout_next = 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
        cnt_next     = cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    state_next = GRANTED;
                    grant_next = pick_onehot;
                    id_next    = pick_id;
                    valid_next = 1'b1;
`ifdef RR_GRANT_TIMEOUT_EN
                    cnt_next   = '0;
`endif
                end
            end
            GRANTED: begin
                if (rel_cond) begin
                    state_next = GAP;
                    grant_next = '0;
                    valid_next = 1'b0;
                    ptr_next   = ptr_after;
                end
`ifdef RR_GRANT_TIMEOUT_EN
                else if (cnt_limit) begin
                    state_next   = GAP;
                    grant_next   = '0;
                    valid_next   = 1'b0;
                    ptr_next     = ptr_after;
                    timeout_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
`endif
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
                valid_next = 1'b0;
            end
        endcase
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            grant_reg   <= '0;
            id_reg      <= '0;
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            grant_reg   <= grant_next;
            id_reg      <= id_next;
            valid_reg   <= valid_next;
            timeout_reg <= timeout_next;
        end
    end

`ifdef RR_GRANT_TIMEOUT_EN
    // Hold counter for the active grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end
    assign bus.timeout = timeout_reg;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.grant       = grant_reg;
    assign bus.grant_id    = id_reg;
    assign bus.grant_valid = valid_reg;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl (NREQ=6, IDW=3, TIMEOUT=16).
// Outputs are sampled on the falling edge; inputs change right after sampling.
module tb_rr_grant_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rr_grant_ctrl_if #(.NREQ(6), .IDW(3)) bus ();

    rr_grant_ctrl #(.NREQ(6), .IDW(3), .TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Packed view of all outputs: {grant[0:5], grant_id, grant_valid, timeout}
    logic [10:0] obs;
    logic [10:0] exp_v;
    assign obs = {bus.grant, bus.grant_id, bus.grant_valid, bus.timeout};

    function automatic logic [10:0] ev(logic [5:0] g, logic [2:0] id, logic v, logic t);
        return {g, id, v, t};
    endfunction

    task automatic step(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.done = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    // Reset state, single grant with done, gap, pointer advance to 3.
    task automatic test_reset();
        do_reset();
        exp_v = ev(6'b000000, 3'd0, 1'b0, 1'b0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL reset_state: got %b expected %b", obs, exp_v); end
        bus.req = 6'b001000;
        step();
        exp_v = ev(6'b001000, 3'd2, 1'b1, 1'b0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t1_grant2: got %b expected %b", obs, exp_v); end
        step(2);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t1_hold2: got %b expected %b", obs, exp_v); end
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        bus.req  = 6'b111111;
        exp_v = ev(6'b000000, 3'd2, 1'b0, 1'b0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t1_gap: got %b expected %b", obs, exp_v); end
        step();
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t1_idle: got %b expected %b", obs, exp_v); end
        step();
        exp_v = ev(6'b000100, 3'd3, 1'b1, 1'b0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t1_ptr3: got %b expected %b", obs, exp_v); end
        bus.req = '0;
        step();
    endtask

    // All requesting: ids 0..5,0 with gap + arbitration cycles between grants.
    task automatic test_rotation();
        logic [5:0] g;
        logic [2:0] id;
        do_reset();
        bus.req = 6'b111111;
        for (int i = 0; i < 7; i++) begin
            id = 3'(i % 6);
            g  = 6'b100000 >> (i % 6);
            step();
            exp_v = ev(g, id, 1'b1, 1'b0);
            checks++; if (obs !== exp_v) begin errors++; $display("FAIL t2_grant[%0d]: got %b expected %b", i, obs, exp_v); end
            bus.done = 1'b1;
            step();
            bus.done = 1'b0;
            exp_v = ev(6'b000000, id, 1'b0, 1'b0);
            checks++; if (obs !== exp_v) begin errors++; $display("FAIL t2_gap[%0d]: got %b expected %b", i, obs, exp_v); end
            step();
            checks++; if (obs !== exp_v) begin errors++; $display("FAIL t2_idle[%0d]: got %b expected %b", i, obs, exp_v); end
        end
        bus.req = '0;
    endtask

    // Pointer 5 after grant to 4, then wrap from 5 to 0.
    task automatic test_wrap();
        do_reset();
        bus.req = 6'b000010;
        step();
        exp_v = ev(6'b000010, 3'd4, 1'b1, 1'b0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t3_grant4: got %b expected %b", obs, exp_v); end
        bus.done = 1'b1;
        bus.req  = 6'b100001;
        step();
        bus.done = 1'b0;
        step(2);
        exp_v = ev(6'b000001, 3'd5, 1'b1, 1'b0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t3_grant5: got %b expected %b", obs, exp_v); end
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        exp_v = ev(6'b000000, 3'd5, 1'b0, 1'b0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t3_gap5: got %b expected %b", obs, exp_v); end
        step(2);
        exp_v = ev(6'b100000, 3'd0, 1'b1, 1'b0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t3_wrap0: got %b expected %b", obs, exp_v); end
        bus.req = '0;
        step(3);
    endtask

    // Withdrawal release, other req changes ignored, done+withdraw single release.
    task automatic test_withdraw();
        do_reset();
        bus.req = 6'b000100;
        step();
        exp_v = ev(6'b000100, 3'd3, 1'b1, 1'b0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t4_grant3: got %b expected %b", obs, exp_v); end
        bus.req = 6'b000111;
        step();
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t4_others_ignored: got %b expected %b", obs, exp_v); end
        bus.req = 6'b010010;
        step();
        exp_v = ev(6'b000000, 3'd3, 1'b0, 1'b0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t4_withdraw_gap: got %b expected %b", obs, exp_v); end
        step();
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t4_no_grant_in_gap: got %b expected %b", obs, exp_v); end
        step();
        exp_v = ev(6'b000010, 3'd4, 1'b1, 1'b0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t4_ptr4: got %b expected %b", obs, exp_v); end
        bus.done = 1'b1;
        bus.req  = 6'b010000;
        step();
        bus.done = 1'b0;
        exp_v = ev(6'b000000, 3'd4, 1'b0, 1'b0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t4_both_gap: got %b expected %b", obs, exp_v); end
        step(2);
        exp_v = ev(6'b010000, 3'd1, 1'b1, 1'b0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t4_grant1: got %b expected %b", obs, exp_v); end
        bus.req = '0;
        step();
        exp_v = ev(6'b000000, 3'd1, 1'b0, 1'b0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t4_release1: got %b expected %b", obs, exp_v); end
        step(2);
    endtask

    // Reset while granted: outputs clear at that edge, search restarts at 0.
    task automatic test_reset_mid_grant();
        do_reset();
        bus.req = 6'b000010;
        step();
        exp_v = ev(6'b000010, 3'd4, 1'b1, 1'b0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t5_grant4: got %b expected %b", obs, exp_v); end
        rst_n   = 1'b0;
        bus.req = 6'b111111;
        step();
        exp_v = ev(6'b000000, 3'd0, 1'b0, 1'b0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t5_reset_clear: got %b expected %b", obs, exp_v); end
        rst_n = 1'b1;
        step();
        exp_v = ev(6'b100000, 3'd0, 1'b1, 1'b0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t5_restart0: got %b expected %b", obs, exp_v); end
        bus.req = '0;
        step(3);
    endtask

    // Grant held without done: forced release with the feature, else held.
    task automatic test_timeout();
        int bad;
        do_reset();
        bus.req = 6'b000001;
        step();
        exp_v = ev(6'b000001, 3'd5, 1'b1, 1'b0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t6_grant5: got %b expected %b", obs, exp_v); end
        bad = 0;
`ifdef RR_GRANT_TIMEOUT_EN
        for (int i = 1; i < 16; i++) begin
            step();
            if (obs !== exp_v) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL t6_hold16: got %0d bad cycles expected 0", bad); end
        step();
        exp_v = ev(6'b000000, 3'd5, 1'b0, 1'b1);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t6_forced: got %b expected %b", obs, exp_v); end
        step();
        exp_v = ev(6'b000000, 3'd5, 1'b0, 1'b0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t6_pulse_end: got %b expected %b", obs, exp_v); end
        step();
        exp_v = ev(6'b000001, 3'd5, 1'b1, 1'b0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t6_regrant: got %b expected %b", obs, exp_v); end
`else
        for (int i = 0; i < 110; i++) begin
            step();
            if (obs !== exp_v) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL t6_hold_forever: got %0d bad cycles expected 0", bad); end
`endif
        bus.req = '0;
        step();
        exp_v = ev(6'b000000, 3'd5, 1'b0, 1'b0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t6_release: got %b expected %b", obs, exp_v); end
        step(2);
    endtask

    initial begin
        bus.req  = '0;
        bus.done = 1'b0;
        test_reset();
        test_rotation();
        test_wrap();
        test_withdraw();
        test_reset_mid_grant();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_grant_ctrl.md
Name: rr_grant_ctrl

Overview:
- Round-robin arbiter and sequencer sharing one downstream resource between NREQ requesters.
- Requesters raise a bit in a request vector. The block grants one requester at a time and holds the grant until the resource signals completion.
- It then inserts a one-cycle idle gap and re-arbitrates, starting after the last winner.
- Sits between the requester-side vectors and the single shared datapath port.

Parameters:
NREQ, 6, number of requesters; request/grant vectors use ascending range [0:NREQ-1]
IDW, 3, width of encoded grant index; must satisfy 2**IDW >= NREQ
TIMEOUT, 16, max cycles a grant may be held (used only with the optional feature); legal range 2..2**16

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
req  input  [0:NREQ-1]  request vector, bit i = requester i wants the resource
done  input  1  resource completion strobe for the current grant
grant  output  [0:NREQ-1]  one-hot grant vector, registered
grant_id  output  IDW  index of granted requester, valid when grant_valid=1
grant_valid  output  1  a grant is active
timeout  output  1  one-cycle pulse on forced release; tied 0 without the optional feature

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a rising edge of clk):
  - grant=0, grant_id=0, grant_valid=0, timeout=0.
  - Round-robin pointer ptr=0, state=IDLE.
  - Reset mid-grant drops the grant at that edge; no gap cycle follows.
- States are IDLE, GRANTED and GAP. All outputs are registered.
- IDLE:
  - If req != 0, select the first set bit at index ptr, ptr+1, ... NREQ-1, 0, ... ptr-1 (wrapping).
  - At the next edge: grant[id]=1, grant_id=id, grant_valid=1, go to GRANTED.
  - Latency from req edge to grant_valid is 1 cycle.
  - If req=0, stay in IDLE with outputs 0.
  - done is ignored in IDLE and GAP.
- GRANTED:
  - Hold grant, grant_id and grant_valid stable.
  - Release when done=1, or when req[grant_id]=0 (requester withdrew).
  - On release, at the next edge: grant=0, grant_valid=0, ptr=(grant_id+1) mod NREQ (NREQ-1 wraps to 0), go to GAP.
  - If done and the withdrawal occur together, this is a single release.
  - Changes to other req bits while GRANTED have no effect.
- GAP:
  - Exactly one cycle with all grant outputs 0, then IDLE.
  - Guarantees at least one dead cycle between consecutive owners.
  - Back-to-back grants therefore have a minimum period of: hold cycles + 1 gap cycle + 1 arbitration cycle.
- Invariants:
  - grant is always zero or one-hot.
  - grant_valid == |grant.
  - grant_id is meaningful only when grant_valid=1 and holds its last value otherwise; reset value is 0.
- Fairness: with all requesters continuously requesting, every requester is granted once in each NREQ consecutive grants.

Optional Feature:
Macro RR_GRANT_TIMEOUT_EN.
- Defined:
  - A hold counter of width clog2(TIMEOUT) clears on entry to GRANTED and increments each GRANTED cycle.
  - If it reaches TIMEOUT-1 with no release condition, the next edge forces release exactly as a normal release: ptr advances, state goes to GAP.
  - timeout=1 for that one cycle (the first GAP cycle).
  - done and the counter limit reached in the same cycle count as a normal release, and timeout stays 0.
- Not defined: no counter is built, timeout is constant 0, and a grant is held indefinitely until release.

Test Plan:
1. Reset then req=6'b001000 (bit 2) -> grant_valid=1, grant_id=2 one cycle later; with done pulsed 3 cycles later -> grant drops next edge, 1 GAP cycle, ptr=3.
2. req=6'b111111 held, done pulsed each grant -> grant_id sequence 0,1,2,3,4,5,0; never two grant bits set; at least 1 zero cycle between grants.
3. ptr=5 (last grant id 4), req=6'b100001 -> grant_id=5, then 0 (wrap check).
4. Granted requester 3 drops req[3] without done -> release next edge, GAP, ptr=4; a simultaneous req[1] rise is not granted until after GAP.
5. rst_n=0 while GRANTED with grant_id=4 -> all outputs 0 at that edge, next grant after reset starts search at index 0.
6. With RR_GRANT_TIMEOUT_EN and TIMEOUT=16, grant held with no done -> forced release after 16 grant cycles, timeout=1 for one cycle; without the macro, the same stimulus holds the grant ≥100 cycles with timeout=0.
